// File: rtl/sys_ctrl_pkg.sv
// Shared constants and types for the command controller: frame command codes,
// the controller state encoding and the fixed ALU operand register addresses.
package sys_ctrl_pkg;

  // First byte of each frame selects the command.
  localparam logic [7:0] CMD_RF_WR   = 8'hAA;  // AA, addr, data
  localparam logic [7:0] CMD_RF_RD   = 8'hBB;  // BB, addr -> 1 byte back
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;  // CC, A, B, fun -> 2 bytes back
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;  // DD, fun -> 2 bytes back

  // Register-file slots that hold the ALU operands.
  localparam int unsigned ALU_OPA_ADDR = 0;
  localparam int unsigned ALU_OPB_ADDR = 1;

  typedef enum logic [3:0] {
    IDLE        = 4'd0,
    WR_ADDR     = 4'd1,
    WR_DATA     = 4'd2,
    RD_ADDR     = 4'd3,
    RD_WAIT     = 4'd4,
    RD_SEND     = 4'd5,
    ALU_A       = 4'd6,
    ALU_B       = 4'd7,
    ALU_FUN     = 4'd8,
    ALU_WAIT    = 4'd9,
    ALU_SEND_LO = 4'd10,
    ALU_SEND_HI = 4'd11
  } state_t;

endpackage

// File: rtl/sys_ctrl.sv
// Command controller: decodes byte frames from the UART receiver, drives the
// register file and ALU, and pushes response bytes into the TX FIFO.
//
// Strobe semantics: every input strobe (rx_d_vld, rf_rd_data_vld,
// alu_out_vld) is a one-cycle qualifier for its data bus and is only acted on
// in the state that expects it. Every output strobe (rf_wr_en, rf_rd_en,
// alu_en, tx_d_vld) is a one-cycle pulse, combinational from the state and the
// current inputs; tx_d_vld is only raised while fifo_full is low, and
// tx_p_data stays stable while a send is held off by fifo_full.
module sys_ctrl
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   rx_p_data,
  input  logic                    rx_d_vld,
  input  logic [DATA_WIDTH-1:0]   rf_rd_data,
  input  logic                    rf_rd_data_vld,
  input  logic [2*DATA_WIDTH-1:0] alu_out,
  input  logic                    alu_out_vld,
  input  logic                    fifo_full,
  output logic [ADDR_WIDTH-1:0]   rf_addr,
  output logic                    rf_wr_en,
  output logic                    rf_rd_en,
  output logic [DATA_WIDTH-1:0]   rf_wr_data,
  output logic                    alu_en,
  output logic [FUN_WIDTH-1:0]    alu_fun,
  output logic                    clk_gate_en,
  output logic [DATA_WIDTH-1:0]   tx_p_data,
  output logic                    tx_d_vld
);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   tx_q;
  logic [2*DATA_WIDTH-1:0] result_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Capture registers: write address, read-back byte and ALU result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      tx_q     <= '0;
      result_q <= '0;
    end else begin
      if (state_q == WR_ADDR && rx_d_vld)        addr_q   <= rx_p_data[ADDR_WIDTH-1:0];
      if (state_q == RD_WAIT && rf_rd_data_vld)  tx_q     <= rf_rd_data;
      if (state_q == ALU_WAIT && alu_out_vld)    result_q <= alu_out;
    end
  end

  // Next-state and output decode; bytes arriving in wait/send states fall
  // through the defaults and are dropped.
  always_comb begin
    state_d     = state_q;
    rf_addr     = '0;
    rf_wr_en    = 1'b0;
    rf_rd_en    = 1'b0;
    rf_wr_data  = '0;
    alu_en      = 1'b0;
    alu_fun     = '0;
    clk_gate_en = 1'b0;
    tx_p_data   = '0;
    tx_d_vld    = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_d_vld) begin
          if (rx_p_data == DATA_WIDTH'(CMD_RF_WR))        state_d = WR_ADDR;
          else if (rx_p_data == DATA_WIDTH'(CMD_RF_RD))   state_d = RD_ADDR;
          else if (rx_p_data == DATA_WIDTH'(CMD_ALU_OP))  state_d = ALU_A;
          else if (rx_p_data == DATA_WIDTH'(CMD_ALU_NOP)) state_d = ALU_FUN;
        end
      end
      WR_ADDR: begin
        if (rx_d_vld) state_d = WR_DATA;
      end
      WR_DATA: begin
        if (rx_d_vld) begin
          rf_wr_en   = 1'b1;
          rf_addr    = addr_q;
          rf_wr_data = rx_p_data;
          state_d    = IDLE;
        end
      end
      RD_ADDR: begin
        if (rx_d_vld) begin
          rf_rd_en = 1'b1;
          rf_addr  = rx_p_data[ADDR_WIDTH-1:0];
          state_d  = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (rf_rd_data_vld) state_d = RD_SEND;
      end
      RD_SEND: begin
        tx_p_data = tx_q;
        if (!fifo_full) begin
          tx_d_vld = 1'b1;
          state_d  = IDLE;
        end
      end
      ALU_A: begin
        if (rx_d_vld) begin
          rf_wr_en   = 1'b1;
          rf_addr    = ADDR_WIDTH'(ALU_OPA_ADDR);
          rf_wr_data = rx_p_data;
          state_d    = ALU_B;
        end
      end
      ALU_B: begin
        if (rx_d_vld) begin
          rf_wr_en   = 1'b1;
          rf_addr    = ADDR_WIDTH'(ALU_OPB_ADDR);
          rf_wr_data = rx_p_data;
          state_d    = ALU_FUN;
        end
      end
      ALU_FUN: begin
        clk_gate_en = 1'b1;
        if (rx_d_vld) begin
          alu_en  = 1'b1;
          alu_fun = rx_p_data[FUN_WIDTH-1:0];
          state_d = ALU_WAIT;
        end
      end
      ALU_WAIT: begin
        clk_gate_en = 1'b1;
        if (alu_out_vld) state_d = ALU_SEND_LO;
      end
      ALU_SEND_LO: begin
        tx_p_data = result_q[DATA_WIDTH-1:0];
        if (!fifo_full) begin
          tx_d_vld = 1'b1;
          state_d  = ALU_SEND_HI;
        end
      end
      ALU_SEND_HI: begin
        tx_p_data = result_q[2*DATA_WIDTH-1:DATA_WIDTH];
        if (!fifo_full) begin
          tx_d_vld = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sys_ctrl.sv
// Bench for sys_ctrl: directed frames, expected strobes queued in order and
// matched by a negedge monitor, plus direct timing checks in the stimulus.
module tb_sys_ctrl;

  localparam int W = 15;  // {kind[2:0], addr[3:0], data[7:0]}
  localparam logic [2:0] K_WR  = 3'd1;
  localparam logic [2:0] K_RD  = 3'd2;
  localparam logic [2:0] K_ALU = 3'd3;
  localparam logic [2:0] K_TX  = 3'd4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_p_data;
  logic        rx_d_vld;
  logic [7:0]  rf_rd_data;
  logic        rf_rd_data_vld;
  logic [15:0] alu_out;
  logic        alu_out_vld;
  logic        fifo_full;
  logic [3:0]  rf_addr;
  logic        rf_wr_en;
  logic        rf_rd_en;
  logic [7:0]  rf_wr_data;
  logic        alu_en;
  logic [3:0]  alu_fun;
  logic        clk_gate_en;
  logic [7:0]  tx_p_data;
  logic        tx_d_vld;

  logic [W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  sys_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FUN_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_p_data(rx_p_data), .rx_d_vld(rx_d_vld),
    .rf_rd_data(rf_rd_data), .rf_rd_data_vld(rf_rd_data_vld),
    .alu_out(alu_out), .alu_out_vld(alu_out_vld),
    .fifo_full(fifo_full),
    .rf_addr(rf_addr), .rf_wr_en(rf_wr_en), .rf_rd_en(rf_rd_en),
    .rf_wr_data(rf_wr_data), .alu_en(alu_en), .alu_fun(alu_fun),
    .clk_gate_en(clk_gate_en), .tx_p_data(tx_p_data), .tx_d_vld(tx_d_vld)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic exp_push(input logic [2:0] k, input logic [3:0] a, input logic [7:0] d);
    exp_q.push_back({k, a, d});
  endtask

  task automatic sb_match(input string name, input logic [W-1:0] obs);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s unexpected strobe actual=%h expected=none", name, obs);
    end else begin
      e = exp_q.pop_front();
      check(name, 16'(obs), 16'(e));
    end
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_strobes"}, 16'({rf_wr_en, rf_rd_en, alu_en, clk_gate_en, tx_d_vld}), 16'h0);
    check({name, "_buses"}, 16'({rf_addr, alu_fun}), 16'h0);
    check({name, "_data"}, {rf_wr_data, tx_p_data}, 16'h0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (rf_wr_en) sb_match("rf_wr",  {K_WR, rf_addr, rf_wr_data});
      if (rf_rd_en) sb_match("rf_rd",  {K_RD, rf_addr, 8'h00});
      if (alu_en)   sb_match("alu_en", {K_ALU, 4'h0, 4'h0, alu_fun});
      if (tx_d_vld) sb_match("tx",     {K_TX, 4'h0, tx_p_data});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_byte(input logic [7:0] b);
    rx_p_data = b;
    rx_d_vld  = 1'b1;
    step();
    rx_d_vld  = 1'b0;
    rx_p_data = 8'h00;
  endtask

  task automatic pulse_rd(input logic [7:0] d);
    rf_rd_data     = d;
    rf_rd_data_vld = 1'b1;
    step();
    rf_rd_data_vld = 1'b0;
    rf_rd_data     = 8'h00;
  endtask

  task automatic pulse_alu(input logic [15:0] r);
    alu_out     = r;
    alu_out_vld = 1'b1;
    step();
    alu_out_vld = 1'b0;
    alu_out     = 16'h0000;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog run did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    rx_p_data = 8'h00; rx_d_vld = 1'b0;
    rf_rd_data = 8'h00; rf_rd_data_vld = 1'b0;
    alu_out = 16'h0000; alu_out_vld = 1'b0;
    fifo_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;
    step();

    // RF write: AA 05 3C
    exp_push(K_WR, 4'h5, 8'h3C);
    drive_byte(8'hAA);
    drive_byte(8'h05);
    rx_p_data = 8'h3C; rx_d_vld = 1'b1;
    #1 check("wr_same_cycle", 16'(rf_wr_en), 16'h1);
    step();
    rx_d_vld = 1'b0; rx_p_data = 8'h00;

    // RF read: BB 05, data returns two cycles later, push one cycle after
    exp_push(K_RD, 4'h5, 8'h00);
    exp_push(K_TX, 4'h0, 8'h3C);
    drive_byte(8'hBB);
    drive_byte(8'h05);
    step();
    rf_rd_data = 8'h3C; rf_rd_data_vld = 1'b1;
    #1 check("rd_no_early_tx", 16'(tx_d_vld), 16'h0);
    step();
    rf_rd_data_vld = 1'b0; rf_rd_data = 8'h00;
    #1 check("rd_tx_latency", {7'h0, tx_d_vld, tx_p_data}, 16'h013C);
    step();

    // ALU with operands: CC 0A 14 02 -> 00C8
    exp_push(K_WR, 4'h0, 8'h0A);
    exp_push(K_WR, 4'h1, 8'h14);
    exp_push(K_ALU, 4'h0, 8'h02);
    exp_push(K_TX, 4'h0, 8'hC8);
    exp_push(K_TX, 4'h0, 8'h00);
    drive_byte(8'hCC);
    drive_byte(8'h0A);
    check("gate_off_alu_b", 16'(clk_gate_en), 16'h0);
    drive_byte(8'h14);
    check("gate_on_alu_fun", 16'(clk_gate_en), 16'h1);
    drive_byte(8'h02);
    check("gate_on_alu_wait", 16'(clk_gate_en), 16'h1);
    pulse_alu(16'h00C8);
    check("alu_lo_push", {7'h0, tx_d_vld, tx_p_data}, 16'h01C8);
    step();
    check("alu_hi_push", {7'h0, tx_d_vld, tx_p_data}, 16'h0100);
    step();
    check("gate_off_idle", 16'(clk_gate_en), 16'h0);

    // FIFO backpressure: DD 00 -> 1234, full for 5 cycles
    exp_push(K_ALU, 4'h0, 8'h00);
    exp_push(K_TX, 4'h0, 8'h34);
    exp_push(K_TX, 4'h0, 8'h12);
    fifo_full = 1'b1;
    drive_byte(8'hDD);
    drive_byte(8'h00);
    pulse_alu(16'h1234);
    for (int i = 0; i < 5; i++) begin
      check("full_hold", {7'h0, tx_d_vld, tx_p_data}, 16'h0034);
      step();
    end
    fifo_full = 1'b0;
    #1 check("unfull_lo", {7'h0, tx_d_vld, tx_p_data}, 16'h0134);
    step();
    check("unfull_hi", {7'h0, tx_d_vld, tx_p_data}, 16'h0112);
    step();

    // Noise in IDLE, stray result strobes, bytes dropped during RD_WAIT
    drive_byte(8'h55);
    pulse_rd(8'hEE);
    pulse_alu(16'hBEEF);
    exp_push(K_RD, 4'h7, 8'h00);
    exp_push(K_TX, 4'h0, 8'h5A);
    drive_byte(8'hBB);
    drive_byte(8'h07);
    drive_byte(8'hAA);
    drive_byte(8'h11);
    pulse_alu(16'h4321);
    pulse_rd(8'h5A);
    check("noise_rd_tx", {7'h0, tx_d_vld, tx_p_data}, 16'h015A);
    step();

    // Command accepted in the first IDLE cycle after a push
    exp_push(K_WR, 4'h2, 8'h77);
    drive_byte(8'hAA);
    drive_byte(8'h02);
    drive_byte(8'h77);

    // Reset mid-frame: AA 05, reset while 3C is presented, then 3C again
    drive_byte(8'hAA);
    drive_byte(8'h05);
    rst_n = 1'b0;
    rx_p_data = 8'h3C; rx_d_vld = 1'b1;
    #1 check_outputs_zero("midreset");
    step();
    rx_d_vld = 1'b0; rx_p_data = 8'h00;
    rst_n = 1'b1;
    step();
    drive_byte(8'h3C);
    step();

    // Controller still operational after reset
    exp_push(K_WR, 4'h1, 8'h99);
    drive_byte(8'hAA);
    drive_byte(8'h01);
    drive_byte(8'h99);
    repeat (3) step();

    check("scoreboard_drained", 16'(exp_q.size()), 16'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sys_ctrl.md
# sys_ctrl

Command controller between the UART receiver and the system datapath. Decodes byte-framed commands from the RX parallel output, sequences register-file writes/reads and ALU operations, and pushes response bytes into the UART TX FIFO. It is the only master of the register file and ALU enable, and it owns the ALU clock-gate enable.

## Interface

**Parameters**
- `DATA_WIDTH`, 8: byte width of RX, TX and register-file data.
- `ADDR_WIDTH`, 4: register-file address width. The address is taken from the low bits of the address byte.
- `FUN_WIDTH`, 4: ALU function code width. The code is taken from the low bits of the function byte.

**Ports**
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `rx_p_data` in DATA_WIDTH: received byte.
- `rx_d_vld` in 1: one-cycle strobe, `rx_p_data` valid.
- `rf_rd_data` in DATA_WIDTH: register-file read data.
- `rf_rd_data_vld` in 1: read data valid strobe.
- `alu_out` in 2*DATA_WIDTH: ALU result.
- `alu_out_vld` in 1: ALU result valid strobe.
- `fifo_full` in 1: TX FIFO full.
- `rf_addr` out ADDR_WIDTH: register-file address.
- `rf_wr_en` out 1: write strobe.
- `rf_rd_en` out 1: read strobe.
- `rf_wr_data` out DATA_WIDTH: write data.
- `alu_en` out 1: ALU start strobe.
- `alu_fun` out FUN_WIDTH: ALU function.
- `clk_gate_en` out 1: ALU clock enable.
- `tx_p_data` out DATA_WIDTH: byte to TX FIFO.
- `tx_d_vld` out 1: TX FIFO write strobe.

## Operation

**Command codes** (first byte of a frame)
- 0xAA: RF write. Frame is AA, addr, data.
- 0xBB: RF read. Frame is BB, addr. Response is 1 byte.
- 0xCC: ALU with operands. Frame is CC, A, B, fun.
- 0xDD: ALU without operands. Frame is DD, fun.
- Any other byte received in IDLE is discarded.

**States and transitions.** A byte is consumed only in a cycle where `rx_d_vld`=1.
- IDLE: on AA go to WR_ADDR, on BB go to RD_ADDR, on CC go to ALU_A, on DD go to ALU_FUN.
- WR_ADDR: latch the address into `addr_q`, go to WR_DATA.
- WR_DATA: assert `rf_wr_en` with `rf_addr`=`addr_q` and `rf_wr_data`=`rx_p_data`, go to IDLE.
- RD_ADDR: assert `rf_rd_en` with `rf_addr`=`rx_p_data[ADDR_WIDTH-1:0]`, go to RD_WAIT.
- RD_WAIT: on `rf_rd_data_vld`, capture the data into `tx_q`, go to RD_SEND.
- RD_SEND: if `!fifo_full`, push `tx_q` with `tx_d_vld`=1 and go to IDLE. Otherwise hold.
- ALU_A: write the byte to RF address 0, go to ALU_B.
- ALU_B: write the byte to RF address 1, go to ALU_FUN.
- ALU_FUN: assert `alu_en` with `alu_fun`=`rx_p_data[FUN_WIDTH-1:0]`, go to ALU_WAIT.
- ALU_WAIT: on `alu_out_vld`, capture the 16-bit result, go to ALU_SEND_LO.
- ALU_SEND_LO: when not full, push the result bits [7:0].
- ALU_SEND_HI: when not full, push the result bits [15:8], go to IDLE.

**Output rules**
- `rf_*`, `alu_en`, `alu_fun` and `tx_*` are combinational from state plus the current inputs. All strobes are exactly one cycle wide.
- `clk_gate_en`=1 in the ALU_FUN and ALU_WAIT states, and 0 elsewhere.

**Boundary conditions**
- `rx_d_vld` in RD_WAIT, ALU_WAIT or any SEND state: the byte is dropped, with no state change.
- `rf_rd_data_vld` outside RD_WAIT and `alu_out_vld` outside ALU_WAIT are ignored.
- `fifo_full` held indefinitely: the block holds the SEND state, `tx_d_vld`=0, and `tx_p_data` is held stable.
- Reset mid-frame: the block returns to IDLE, the partial frame is discarded, and no strobe is issued.

**Reset values.** All outputs are 0. `addr_q`, `tx_q` and the result register are 0. The state is IDLE.

## Timing

- RF write: `rf_wr_en` is asserted in the same cycle as the data byte's `rx_d_vld`.
- RF read: `rf_rd_en` is asserted in the address byte's `rx_d_vld` cycle. If the FIFO is not full, `tx_d_vld` is asserted one cycle after `rf_rd_data_vld`.
- ALU: `alu_en` is asserted in the function byte's `rx_d_vld` cycle. The low byte is pushed one cycle after `alu_out_vld`, and the high byte in the next non-full cycle, so the two pushes come on consecutive cycles when the FIFO is not full.
- There is no dead cycle after returning to IDLE. A command byte is accepted in the first IDLE cycle.

## Structure

- `sys_ctrl_pkg` holds:
  - command code constants AA, BB, CC and DD;
  - the state enum typedef;
  - the ALU operand addresses, 0 and 1.
- The block is a single module, with no sub-module. The state register, the operand/address/result capture registers and the combinational next-state/output logic all live in one module.

## Test plan

- **RF write.** Drive bytes AA, 05, 3C. Expect one `rf_wr_en` pulse with `rf_addr`=5 and `rf_wr_data`=3C, then the state returns to IDLE.
- **RF read.** Drive BB, 05. Expect `rf_rd_en` with `rf_addr`=5. The model returns 3C after 2 cycles. Expect a `tx_d_vld` pulse with `tx_p_data`=3C one cycle later.
- **ALU with operands.** Drive CC, 0A, 14, 02. Expect RF writes addr0=0A and addr1=14, then `alu_en` with `alu_fun`=2 and `clk_gate_en` high. The ALU returns 00C8. Expect TX bytes C8 then 00.
- **FIFO backpressure.** Run DD, 00 with `alu_out`=1234 and `fifo_full`=1 for 5 cycles. Expect no push while full, then 34 and 12 on consecutive cycles once not full.
- **Noise and drops.** Drive 55 in IDLE: no outputs. Send extra bytes during RD_WAIT: dropped, and the read response is still correct.
- **Reset mid-frame.** Assert `rst_n` after AA, 05. After release, drive 3C. Expect no `rf_wr_en`, and all outputs 0 during reset.
